// File: rtl/seq_div_if.sv
// seq_div_if: operand/control and result bundle between a divide controller and seq_div
interface seq_div_if #(parameter int N = 25);
  logic [N-1:0] dvd, dvs, quot, rem;
  logic start, div_term, sticky, dbz, div_busy, div_done;
  modport master (
    output dvd, dvs, start, div_term,
    input  quot, rem, sticky, dbz, div_busy, div_done
  );
  modport slave (
    input  dvd, dvs, start, div_term,
    output quot, rem, sticky, dbz, div_busy, div_done
  );
endinterface

// File: rtl/seq_div.sv
// seq_div: radix-2 restoring unsigned divider, one quotient bit per clock; SEQ_DIV_EARLY_DBZ_EN short-cuts divide-by-zero
module seq_div #(parameter int N = 25) (
  input logic clk,
  input logic reset,
  seq_div_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  logic [N:0] r, s, t;
  logic [N-1:0] q, d;
  logic [CW-1:0] cnt;
  logic dbz, busy, done;
  assign s = {r[N-1:0], q[N-1]};
  assign t = s - {1'b0, d};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      dbz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (bus.div_term) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      dbz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (bus.start) begin
      r <= '0;
      q <= bus.dvd;
      d <= bus.dvs;
      cnt <= '0;
      dbz <= bus.dvs == '0;
      busy <= 1'b1;
      done <= 1'b0;
`ifdef SEQ_DIV_EARLY_DBZ_EN
    end else if (busy && dbz) begin
      r <= {1'b0, q};
      q <= '1;
      busy <= 1'b0;
      done <= 1'b1;
`endif
    end else if (busy) begin
      r <= t[N] ? s : t;
      q <= {q[N-2:0], ~t[N]};
      cnt <= cnt + 1'b1;
      busy <= cnt != CW'(N - 1);
      done <= cnt == CW'(N - 1);
    end
  end
  assign bus.quot = q;
  assign bus.rem = r[N-1:0];
  // r[N] is always zero once restored, so folding it in keeps sticky == |rem
  assign bus.sticky = |r;
  assign bus.dbz = dbz;
  assign bus.div_busy = busy;
  assign bus.div_done = done;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div (directed, abort, reset and random back-to-back divides)
module tb_seq_div;
  localparam int N = 25;
  localparam int W = 2 * N;
`ifdef SEQ_DIV_EARLY_DBZ_EN
  localparam int DBZ_EDGES = 2;
  localparam int DBZ_BUSY = 1;
`else
  localparam int DBZ_EDGES = N + 1;
  localparam int DBZ_BUSY = N;
`endif
  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic s;
    logic z;
  } exp_t;
  logic clk, reset;
  int total, bad;
  exp_t sb[$];
  seq_div_if #(.N(N)) bus();
  seq_div #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.q = (b == '0) ? '1 : a / b;
    e.r = (b == '0) ? a : a % b;
    e.s = e.r != '0;
    e.z = b == '0;
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.dvd = a;
    bus.dvs = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 1;
    busy_cnt = 0;
    while (!bus.div_done && edges < 4 * N) begin
      if (bus.div_busy) busy_cnt++;
      tick();
      edges++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus.quot, bus.rem, bus.sticky, bus.dbz, bus.div_busy, bus.div_done} !== '0) begin
      bad++;
      $display("FAIL reset: got q=%h r=%h s=%b z=%b busy=%b done=%b want all zero",
               bus.quot, bus.rem, bus.sticky, bus.dbz, bus.div_busy, bus.div_done);
    end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    logic [N-1:0] a_tab [3];
    logic [N-1:0] b_tab [3];
    int edges, bc;
    exp_t e;
    a_tab = '{N'(100), N'(3), N'(25'h1FFFFFF)};
    b_tab = '{N'(7), N'(5), N'(1)};
    for (int i = 0; i < 3; i++) begin
      go(a_tab[i], b_tab[i]);
      wait_done(edges, bc);
      total++;
      if (edges !== N + 1 || bc !== N) begin
        bad++;
        $display("FAIL basic%0d latency: got edges=%0d busy=%0d want edges=%0d busy=%0d", i, edges, bc, N + 1, N);
      end
      e = sb.pop_front();
      total++;
      if ({bus.quot, bus.rem, bus.sticky, bus.dbz} !== {e.q, e.r, e.s, e.z}) begin
        bad++;
        $display("FAIL basic%0d result: got q=%h r=%h s=%b z=%b want q=%h r=%h s=%b z=%b",
                 i, bus.quot, bus.rem, bus.sticky, bus.dbz, e.q, e.r, e.s, e.z);
      end
    end
    repeat (3) tick();
    total++;
    if (bus.div_done !== 1'b1 || bus.quot !== N'(25'h1FFFFFF)) begin
      bad++;
      $display("FAIL hold: got done=%b q=%h want done=1 q=1ffffff", bus.div_done, bus.quot);
    end
  endtask
  task automatic test_dbz();
    int edges, bc;
    exp_t e;
    go(N'(25'h123456), '0);
    total++;
    if (bus.div_done !== 1'b0 || bus.div_busy !== 1'b1 || bus.dbz !== 1'b1) begin
      bad++;
      $display("FAIL dbz_start: got done=%b busy=%b z=%b want done=0 busy=1 z=1", bus.div_done, bus.div_busy, bus.dbz);
    end
    wait_done(edges, bc);
    total++;
    if (edges !== DBZ_EDGES || bc !== DBZ_BUSY) begin
      bad++;
      $display("FAIL dbz latency: got edges=%0d busy=%0d want edges=%0d busy=%0d", edges, bc, DBZ_EDGES, DBZ_BUSY);
    end
    e = sb.pop_front();
    total++;
    if ({bus.quot, bus.rem, bus.sticky, bus.dbz} !== {e.q, e.r, e.s, e.z}) begin
      bad++;
      $display("FAIL dbz result: got q=%h r=%h s=%b z=%b want q=%h r=%h s=%b z=%b",
               bus.quot, bus.rem, bus.sticky, bus.dbz, e.q, e.r, e.s, e.z);
    end
  endtask
  task automatic test_restart();
    int edges, bc;
    exp_t e;
    go(N'(40), N'(6));
    repeat (10) tick();
    sb.delete();
    go(N'(81), N'(9));
    wait_done(edges, bc);
    total++;
    if (edges !== N + 1) begin
      bad++;
      $display("FAIL restart latency: got edges=%0d want %0d", edges, N + 1);
    end
    e = sb.pop_front();
    total++;
    if ({bus.quot, bus.rem, bus.sticky, bus.dbz} !== {e.q, e.r, e.s, e.z}) begin
      bad++;
      $display("FAIL restart result: got q=%h r=%h s=%b z=%b want q=%h r=%h s=%b z=%b",
               bus.quot, bus.rem, bus.sticky, bus.dbz, e.q, e.r, e.s, e.z);
    end
  endtask
  task automatic test_term();
    go(N'(1000), N'(3));
    sb.delete();
    repeat (5) tick();
    bus.div_term = 1'b1;
    tick();
    bus.div_term = 1'b0;
    total++;
    if ({bus.quot, bus.rem, bus.dbz, bus.div_busy, bus.div_done} !== '0) begin
      bad++;
      $display("FAIL term: got q=%h r=%h z=%b busy=%b done=%b want all zero",
               bus.quot, bus.rem, bus.dbz, bus.div_busy, bus.div_done);
    end
    bus.dvd = N'(5);
    bus.dvs = N'(1);
    bus.start = 1'b1;
    bus.div_term = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.div_term = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.quot, bus.div_busy, bus.div_done} !== '0) begin
      bad++;
      $display("FAIL start_term: got q=%h busy=%b done=%b want idle zero", bus.quot, bus.div_busy, bus.div_done);
    end
  endtask
  task automatic test_async_reset();
    go(N'(12345), N'(0));
    sb.delete();
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.quot, bus.rem, bus.sticky, bus.dbz, bus.div_busy, bus.div_done} !== '0) begin
      bad++;
      $display("FAIL async_reset: got q=%h r=%h s=%b z=%b busy=%b done=%b want all zero",
               bus.quot, bus.rem, bus.sticky, bus.dbz, bus.div_busy, bus.div_done);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask
  task automatic test_back_to_back();
    int edges, bc;
    exp_t e;
    logic [N-1:0] a, b;
    logic [W-1:0] lhs;
    for (int i = 0; i < 1500; i++) begin
      a = N'($urandom);
      b = (i % 3 == 0) ? N'($urandom_range(1, 255)) : N'($urandom >> (i % 20));
      if (b == '0) b = N'(1);
      go(a, b);
      wait_done(edges, bc);
      e = sb.pop_front();
      lhs = W'(bus.quot) * W'(b) + W'(bus.rem);
      total++;
      if (!bus.div_done || lhs !== W'(a) || bus.rem >= b || bus.sticky !== (bus.rem != '0)
          || {bus.quot, bus.rem} !== {e.q, e.r}) begin
        bad++;
        $display("FAIL b2b%0d: dvd=%h dvs=%h got done=%b q=%h r=%h s=%b want q=%h r=%h s=%b",
                 i, a, b, bus.div_done, bus.quot, bus.rem, bus.sticky, e.q, e.r, e.s);
      end
    end
  endtask
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.dvd = '0;
    bus.dvs = '0;
    bus.start = 1'b0;
    bus.div_term = 1'b0;
    test_reset();
    test_basic();
    test_dbz();
    test_restart();
    test_term();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
